// File: rtl/tap_scan_ctrl_if.sv
// Bus bundle between tap_scan_ctrl and its user: scan handshake, the sample
// returned from the delay line, the tap select, and the lock result.
// Optional manual tap override ports exist when TAPSCAN_MANUAL_EN is defined.
interface tap_scan_ctrl_if #(
    parameter int unsigned TAP_W    = 5,
    parameter int unsigned DATA_W   = 13,
    parameter int unsigned ACC_LOG2 = 4
);
    logic                       start;
    logic signed [DATA_W-1:0]   din;
    logic [TAP_W-1:0]           tap;
    logic                       busy;
    logic                       done;
    logic [TAP_W-1:0]           best_tap;
    logic [DATA_W+ACC_LOG2-1:0] best_metric;
`ifdef TAPSCAN_MANUAL_EN
    logic                       man_en;
    logic [TAP_W-1:0]           man_tap;
`endif

    modport slave (
        input  start,
        input  din,
`ifdef TAPSCAN_MANUAL_EN
        input  man_en,
        input  man_tap,
`endif
        output tap,
        output busy,
        output done,
        output best_tap,
        output best_metric
    );

    modport master (
        output start,
        output din,
`ifdef TAPSCAN_MANUAL_EN
        output man_en,
        output man_tap,
`endif
        input  tap,
        input  busy,
        input  done,
        input  best_tap,
        input  best_metric
    );
endinterface

// File: rtl/tap_scan_ctrl.sv
// tap_scan_ctrl: sweeps the delay-line tap select over every value, sums
// |din| over a 2^ACC_LOG2-sample window per tap after a settle period, and
// locks the tap with the largest sum (lowest tap wins ties).
// Optional feature macro: TAPSCAN_MANUAL_EN (manual tap override in IDLE).
module tap_scan_ctrl #(
    parameter int unsigned TAP_W    = 5,
    parameter int unsigned DATA_W   = 13,
    parameter int unsigned SETTLE   = 3,
    parameter int unsigned ACC_LOG2 = 4
) (
    input logic             clk,
    input logic             rst_n,
    tap_scan_ctrl_if.slave  bus
);
    localparam int unsigned MET_W = DATA_W + ACC_LOG2;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_COMPARE,
        S_LOCK
    } state_t;

    state_t             state_q;
    logic [TAP_W-1:0]   tap_q;
    logic [TAP_W-1:0]   best_tap_q;
    logic [MET_W-1:0]   best_metric_q;
    logic [MET_W-1:0]   acc_q;
    logic [3:0]         settle_q;
    logic [ACC_LOG2-1:0] samp_q;
    logic               busy_q;
    logic               done_q;

    logic [DATA_W:0]    din_ext;
    logic [DATA_W:0]    din_abs;
    logic [MET_W-1:0]   acc_d;

    // Magnitude on DATA_W+1 bits so the most negative sample maps to +2^(DATA_W-1)
    always_comb begin
        din_ext = {bus.din[DATA_W-1], bus.din};
        din_abs = din_ext[DATA_W] ? (~din_ext + 1'b1) : din_ext;
        acc_d   = acc_q + MET_W'(din_abs);
    end

    // Scan sequencer with registered tap, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tap_q         <= '0;
            best_tap_q    <= '0;
            best_metric_q <= '0;
            acc_q         <= '0;
            settle_q      <= '0;
            samp_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
`ifdef TAPSCAN_MANUAL_EN
                    if (bus.man_en) begin
                        tap_q <= bus.man_tap;
                    end else
`endif
                    if (bus.start) begin
                        state_q       <= S_SETTLE;
                        busy_q        <= 1'b1;
                        tap_q         <= '0;
                        best_tap_q    <= '0;
                        best_metric_q <= '0;
                        acc_q         <= '0;
                        settle_q      <= '0;
                        samp_q        <= '0;
                    end else begin
                        tap_q <= best_tap_q;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= '0;
                        state_q  <= S_ACCUM;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                S_ACCUM: begin
                    acc_q  <= acc_d;
                    samp_q <= samp_q + 1'b1;
                    if (samp_q == '1) begin
                        state_q <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (acc_q > best_metric_q) begin
                        best_metric_q <= acc_q;
                        best_tap_q    <= tap_q;
                    end
                    if (tap_q == '1) begin
                        state_q <= S_LOCK;
                    end else begin
                        tap_q    <= tap_q + 1'b1;
                        acc_q    <= '0;
                        settle_q <= '0;
                        state_q  <= S_SETTLE;
                    end
                end
                S_LOCK: begin
                    tap_q   <= best_tap_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tap         = tap_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.best_tap    = best_tap_q;
    assign bus.best_metric = best_metric_q;

endmodule

// File: tb/tb_tap_scan_ctrl.sv
// Self-checking bench for tap_scan_ctrl: a 2-cycle delay-line model returns a
// per-tap sample profile; expected lock results come from a per-tap metric
// table (16 * |value|) with lowest-tap-wins argmax.
module tb_tap_scan_ctrl;
    localparam int TAP_W    = 5;
    localparam int DATA_W   = 13;
    localparam int ACC_LOG2 = 4;
    localparam int NTAPS    = 1 << TAP_W;
    localparam int NSAMP    = 1 << ACC_LOG2;
    localparam int BUSY_EXP = NTAPS * (3 + NSAMP + 1) + 1;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    tap_scan_ctrl_if #(.TAP_W(TAP_W), .DATA_W(DATA_W), .ACC_LOG2(ACC_LOG2)) bus ();

    tap_scan_ctrl #(
        .TAP_W   (TAP_W),
        .DATA_W  (DATA_W),
        .SETTLE  (3),
        .ACC_LOG2(ACC_LOG2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay line: per-tap sample value returned two registered cycles later
    logic signed [DATA_W-1:0] prof [NTAPS];
    logic signed [DATA_W-1:0] dl1, dl2;
    always @(posedge clk) begin
        dl1 <= prof[bus.tap];
        dl2 <= dl1;
    end
    assign bus.din = dl2;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_best(output int bt, output longint bm);
        bt = 0;
        bm = 0;
        for (int t = 0; t < NTAPS; t++) begin
            int v;
            longint m;
            v = prof[t];
            m = NSAMP * ((v < 0) ? -v : v);
            if (m > bm) begin
                bm = m;
                bt = t;
            end
        end
    endfunction

    function automatic void set_all(input int v);
        for (int t = 0; t < NTAPS; t++) prof[t] = DATA_W'(v);
    endfunction

    function automatic void set_random();
        for (int t = 0; t < NTAPS; t++) begin
            int v;
            v = int'($urandom_range(0, 8191)) - 4096;
            prof[t] = DATA_W'(v);
        end
    endfunction

    task automatic do_scan(input int late_at, output int bcnt, output int dcnt);
        bcnt = 0;
        dcnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_tap", bus.tap, 0);
        bcnt = 1;
        for (int i = 0; i < 2000 && dcnt == 0; i++) begin
            @(negedge clk);
            bus.start = (bcnt == late_at);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                dcnt++;
                chk("done_busy_low", bus.busy, 0);
            end
        end
        bus.start = 1'b0;
        if (dcnt == 0) chk("scan_timeout", 0, 1);
        repeat (30) begin
            @(negedge clk);
            if (bus.done) dcnt++;
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic scan_and_check(input int late_at);
        int bcnt, dcnt, bt;
        longint bm;
        do_scan(late_at, bcnt, dcnt);
        ref_best(bt, bm);
        chk("busy_cycles", bcnt, BUSY_EXP);
        chk("done_count", dcnt, 1);
        chk("best_tap", bus.best_tap, bt);
        chk("best_metric", bus.best_metric, bm);
        chk("tap_locked", bus.tap, bt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bt, dc;
        longint bm;
        bit seen;
        rst_n     = 1'b0;
        bus.start = 1'b0;
`ifdef TAPSCAN_MANUAL_EN
        bus.man_en  = 1'b0;
        bus.man_tap = '0;
`endif
        set_all(0);
        repeat (3) @(negedge clk);
        chk("rst_tap", bus.tap, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_best_tap", bus.best_tap, 0);
        chk("rst_best_metric", bus.best_metric, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        // Flat input
        set_all(100);
        scan_and_check(0);
        chk("flat_metric_abs", bus.best_metric, 1600);

        // Peaked at tap 17, random small magnitudes elsewhere
        for (int t = 0; t < NTAPS; t++) begin
            int m;
            m = int'($urandom_range(0, 500));
            if ($urandom_range(0, 1) != 0) m = -m;
            prof[t] = DATA_W'(m);
        end
        prof[17] = DATA_W'(3000);
        scan_and_check(0);
        chk("peak_tap_abs", bus.best_tap, 17);

        // Negative full scale on the last tap only
        set_all(0);
        prof[31] = DATA_W'(-4096);
        scan_and_check(0);
        chk("negfs_metric_abs", bus.best_metric, 65536);

        // Tie between taps 5 and 9, plus a start pulse mid-scan
        set_all(0);
        prof[5] = DATA_W'(200);
        prof[9] = DATA_W'(200);
        scan_and_check(300);
        chk("tie_tap_abs", bus.best_tap, 5);

        // Random profiles
        for (int n = 0; n < 3; n++) begin
            set_random();
            scan_and_check(0);
        end

        // Reset in the middle of tap 12
        set_random();
        prof[3] = DATA_W'(4000);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (bus.tap == 12) seen = 1'b1;
        end
        chk("reach_tap12", seen, 1);
        repeat (5) @(negedge clk);
        chk("pre_rst_best_nonzero", (bus.best_metric != 0), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tap", bus.tap, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_best_tap", bus.best_tap, 0);
        chk("mid_rst_best_metric", bus.best_metric, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.done || bus.busy) dc++;
        end
        chk("post_rst_quiet", dc, 0);
        scan_and_check(0);

        // start held high across LOCK restarts one cycle after done
        set_random();
        @(negedge clk);
        bus.start = 1'b1;
        dc = 0;
        for (int i = 0; i < 2000 && dc == 0; i++) begin
            @(negedge clk);
            if (bus.done) dc++;
        end
        chk("held_first_done", dc, 1);
        ref_best(bt, bm);
        chk("held_best_tap", bus.best_tap, bt);
        chk("held_best_metric", bus.best_metric, bm);
        @(negedge clk);
        bus.start = 1'b0;
        chk("held_restart_busy", bus.busy, 1);
        chk("held_restart_tap", bus.tap, 0);
        dc = 0;
        for (int i = 0; i < 2000 && dc == 0; i++) begin
            @(negedge clk);
            if (bus.done) dc++;
        end
        chk("held_second_done", dc, 1);
        chk("held2_best_tap", bus.best_tap, bt);
        chk("held2_best_metric", bus.best_metric, bm);

`ifdef TAPSCAN_MANUAL_EN
        // Manual override in IDLE
        ref_best(bt, bm);
        @(negedge clk);
        bus.man_en  = 1'b1;
        bus.man_tap = 5'd22;
        @(negedge clk);
        chk("man_tap", bus.tap, 22);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("man_start_ignored", bus.busy, 0);
        chk("man_tap_hold", bus.tap, 22);
        bus.man_en = 1'b0;
        @(negedge clk);
        chk("man_release_tap", bus.tap, bt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tap_scan_ctrl.md
# tap_scan_ctrl

Scan-and-lock controller for the signed variable delay line. It sweeps the delay line's tap select through every value and measures the magnitude of the delayed output at each tap by accumulating |sample| over a fixed window. It then locks the tap that gave the largest metric. It sits beside the delay line in the feedback/alignment path: its `tap` output drives the delay line's tap input, and the delay line's registered output returns on `din`.

## Interface
- `TAP_W`, default 5: tap select width; the scan covers taps 0..2^TAP_W-1.
- `DATA_W`, default 13: signed sample width of `din`.
- `SETTLE`, default 3: cycles waited after each tap change before accumulating. Legal range is 2..15, because the delay line's output register adds 2 cycles.
- `ACC_LOG2`, default 4: log2 of the number of samples accumulated per tap.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `din`  in  DATA_W signed  delayed sample returned from the delay line.
- `tap`  out  TAP_W  tap select driven to the delay line.
- `busy`  out  1  high while a scan is running.
- `done`  out  1  single-cycle pulse when the scan completes.
- `best_tap`  out  TAP_W  tap locked by the last completed scan.
- `best_metric`  out  DATA_W+ACC_LOG2 unsigned  metric of `best_tap`.

## Operation
- **States:** IDLE, SETTLE, ACCUM, COMPARE, LOCK.
- **IDLE:**
  - `start`=1 → SETTLE.
  - On that transition: `tap`←0, `best_metric`←0, `best_tap`←0, accumulator←0, settle counter←0.
- **SETTLE:**
  - Count SETTLE cycles.
  - On the last count → ACCUM.
- **ACCUM:**
  - Each cycle, acc += |din|.
  - |din| is computed on DATA_W+1 bits, so the most negative input gives +2^(DATA_W-1). For DATA_W=13, -4096 → 4096.
  - The accumulator is DATA_W+ACC_LOG2 bits wide and cannot overflow.
  - After 2^ACC_LOG2 samples → COMPARE.
- **COMPARE (1 cycle):**
  - If acc > `best_metric` (strictly greater): `best_metric`←acc, `best_tap`←`tap`.
  - On ties the lower tap is kept.
  - If `tap` = 2^TAP_W-1 → LOCK.
  - Otherwise: `tap`←`tap`+1, acc←0, → SETTLE.
  - `tap` never wraps.
- **LOCK (1 cycle):** `tap`←`best_tap` (including the update made in the final COMPARE), `done`←1, → IDLE.
- **Outside a scan:** `tap` holds `best_tap`.
- **`start` while busy:** ignored; it is not queued.
- **`start` held high across LOCK:** `start` is sampled again in IDLE, so the next scan begins one cycle after `done`.
- **Reset (asynchronous, including mid-scan):**
  - State IDLE; `tap`=0, `busy`=0, `done`=0, `best_tap`=0, `best_metric`=0; accumulator and counters 0.
  - A scan interrupted by reset produces no `done` and leaves no partial result.

## Timing
- `start` sampled high at edge k → `busy`=1 and `tap`=0 visible after edge k.
- **Per tap:** SETTLE + 2^ACC_LOG2 + 1 cycles. With defaults that is 3+16+1 = 20.
- **Full scan with defaults:**
  - `busy` is high for 32×20 + 1 = 641 cycles; the final cycle is LOCK.
  - `done` is high in the cycle after LOCK, coinciding with `busy` falling to 0.
  - `tap`, `best_tap` and `best_metric` are final and stable in that same cycle.
- **Sample window for tap t:** the 2^ACC_LOG2 `din` values sampled during ACCUM. With SETTLE ≥ 2, the delay line's 2-cycle output latency is fully flushed before the first sample.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- **`TAPSCAN_MANUAL_EN`** adds two ports: `man_en` (in, 1) and `man_tap` (in, TAP_W).
- **Defined, IDLE with `man_en`=1:**
  - `tap` follows `man_tap` with 1-cycle latency.
  - `start` is ignored.
- **Defined, during a scan:** `man_en`=1 is ignored until IDLE is reached.
- **Defined, `man_en`=0 in IDLE:** `tap` returns to `best_tap` on the next cycle.
- **Not defined:** the ports are absent, and `tap` is driven only by the scan/lock logic described above.

## Test plan
- **Flat input:** `din` constant +100 on every tap → `done` after 641 busy cycles; `best_tap`=0, `best_metric`=1600, `tap`=0.
- **Peaked input:** bench delay-line model, input pulse train whose magnitude peaks at tap 17 (|din|=3000 there, ≤500 elsewhere) → `best_tap`=17, `best_metric`=48000, `tap`=17 after `done`.
- **Negative full scale:** `din` = -4096 only while `tap`=31, 0 elsewhere → `best_tap`=31, `best_metric`=65536; no overflow.
- **Tie and late start:** `din` = +200 for taps 5 and 9, 0 elsewhere → `best_tap`=5. A second `start` pulse at busy cycle 300 → no restart; exactly one `done`.
- **Reset mid-scan:** `rst_n` low during tap 12 → all outputs 0 immediately; no `done`. A fresh `start` after release completes normally.
- **Manual mode (`TAPSCAN_MANUAL_EN` defined):** `man_en`=1, `man_tap`=22 in IDLE → `tap`=22 next cycle, and `start` is ignored. `man_en`=0 → `tap` returns to `best_tap` one cycle later.
